// File: rtl/alu_share_arb.sv
// Two-port arbiter that shares one combinational EXE ALU and returns results through a one-entry response register.
// Optional performance counters are enabled by defining ALU_ARB_PERF_EN.
module alu_share_arb #(
    parameter bit RR_INIT = 1'b0,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_rs1,
    input  logic [31:0] req0_rs2,
    input  logic [4:0]  req0_shamt,
    input  logic [2:0]  req0_funct3,
    input  logic        req0_subright,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_rs1,
    input  logic [31:0] req1_rs2,
    input  logic [4:0]  req1_shamt,
    input  logic [2:0]  req1_funct3,
    input  logic        req1_subright,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    output logic [4:0]  alu_shamt,
    output logic [2:0]  alu_funct3,
    output logic        alu_subright,
    input  logic [31:0] alu_result,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_grant0,
    output logic [CNT_W-1:0] perf_grant1,
    output logic [CNT_W-1:0] perf_stall
`endif
);

    logic        rr_ptr_q, rr_ptr_d;
    logic        rsp_full_q, rsp_full_d;
    logic        rsp_owner_q, rsp_owner_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    logic drain_s;
    logic can_accept_s;
    logic gnt_valid_s;
    logic gnt_idx_s;
    logic accept_s;

    // Drain, grant selection and accept qualification
    always_comb begin
        drain_s      = rsp_full_q & (rsp_owner_q ? rsp1_ready : rsp0_ready);
        can_accept_s = ~rsp_full_q | drain_s;
        gnt_valid_s  = 1'b0;
        gnt_idx_s    = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_valid_s = 1'b1;
            gnt_idx_s   = rr_ptr_q;
        end else if (req0_valid) begin
            gnt_valid_s = 1'b1;
            gnt_idx_s   = 1'b0;
        end else if (req1_valid) begin
            gnt_valid_s = 1'b1;
            gnt_idx_s   = 1'b1;
        end else begin
            gnt_valid_s = 1'b0;
            gnt_idx_s   = 1'b0;
        end
        // rst_n gating keeps both readies low for the whole reset window
        req0_ready = rst_n & can_accept_s & gnt_valid_s & ~gnt_idx_s;
        req1_ready = rst_n & can_accept_s & gnt_valid_s & gnt_idx_s;
        accept_s   = req0_ready | req1_ready;
    end

    // ALU operand mux; idle drive is all zeros to keep the ALU quiet
    always_comb begin
        alu_rs1      = 32'h0000_0000;
        alu_rs2      = 32'h0000_0000;
        alu_shamt    = 5'd0;
        alu_funct3   = 3'b000;
        alu_subright = 1'b0;
        if (gnt_valid_s) begin
            if (gnt_idx_s) begin
                alu_rs1      = req1_rs1;
                alu_rs2      = req1_rs2;
                alu_shamt    = req1_shamt;
                alu_funct3   = req1_funct3;
                alu_subright = req1_subright;
            end else begin
                alu_rs1      = req0_rs1;
                alu_rs2      = req0_rs2;
                alu_shamt    = req0_shamt;
                alu_funct3   = req0_funct3;
                alu_subright = req0_subright;
            end
        end else begin
            alu_rs1      = 32'h0000_0000;
            alu_rs2      = 32'h0000_0000;
            alu_shamt    = 5'd0;
            alu_funct3   = 3'b000;
            alu_subright = 1'b0;
        end
    end

    // Response register and round-robin pointer next state
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        rsp_full_d  = rsp_full_q;
        rsp_owner_d = rsp_owner_q;
        rsp_data_d  = rsp_data_q;
        if (accept_s) begin
            rsp_data_d  = alu_result;
            rsp_owner_d = gnt_idx_s;
            rsp_full_d  = 1'b1;
            rr_ptr_d    = ~gnt_idx_s;
        end else if (drain_s) begin
            rsp_full_d = 1'b0;
        end else begin
            rsp_full_d = rsp_full_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= RR_INIT;
            rsp_full_q  <= 1'b0;
            rsp_owner_q <= 1'b0;
            rsp_data_q  <= 32'h0000_0000;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_full_q  <= rsp_full_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp0_valid = rsp_full_q & ~rsp_owner_q;
    assign rsp1_valid = rsp_full_q & rsp_owner_q;
    assign rsp_result = rsp_data_q;

`ifdef ALU_ARB_PERF_EN
    logic [CNT_W-1:0] perf_grant0_q, perf_grant0_d;
    logic [CNT_W-1:0] perf_grant1_q, perf_grant1_d;
    logic [CNT_W-1:0] perf_stall_q, perf_stall_d;

    // Saturating performance counters
    always_comb begin
        perf_grant0_d = perf_grant0_q;
        perf_grant1_d = perf_grant1_q;
        perf_stall_d  = perf_stall_q;
        if (req0_ready && (perf_grant0_q != {CNT_W{1'b1}})) begin
            perf_grant0_d = perf_grant0_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            perf_grant0_d = perf_grant0_q;
        end
        if (req1_ready && (perf_grant1_q != {CNT_W{1'b1}})) begin
            perf_grant1_d = perf_grant1_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            perf_grant1_d = perf_grant1_q;
        end
        if ((req0_valid || req1_valid) && !accept_s && (perf_stall_q != {CNT_W{1'b1}})) begin
            perf_stall_d = perf_stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            perf_stall_d = perf_stall_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grant0_q <= {CNT_W{1'b0}};
            perf_grant1_q <= {CNT_W{1'b0}};
            perf_stall_q  <= {CNT_W{1'b0}};
        end else begin
            perf_grant0_q <= perf_grant0_d;
            perf_grant1_q <= perf_grant1_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_grant0 = perf_grant0_q;
    assign perf_grant1 = perf_grant1_q;
    assign perf_stall  = perf_stall_q;
`else
    logic [CNT_W-1:0] perf_unused_s;
    assign perf_unused_s = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_alu_share_arb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req0_valid, req0_ready, req0_subright;
    logic [31:0] req0_rs1, req0_rs2;
    logic [4:0]  req0_shamt;
    logic [2:0]  req0_funct3;
    logic        req1_valid, req1_ready, req1_subright;
    logic [31:0] req1_rs1, req1_rs2;
    logic [4:0]  req1_shamt;
    logic [2:0]  req1_funct3;
    logic [31:0] alu_rs1, alu_rs2, alu_result, rsp_result;
    logic [4:0]  alu_shamt;
    logic [2:0]  alu_funct3;
    logic        alu_subright;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
`ifdef ALU_ARB_PERF_EN
    logic [15:0] perf_grant0, perf_grant1, perf_stall;
`endif

    alu_share_arb #(.RR_INIT(1'b0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
        .req0_shamt(req0_shamt), .req0_funct3(req0_funct3), .req0_subright(req0_subright),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
        .req1_shamt(req1_shamt), .req1_funct3(req1_funct3), .req1_subright(req1_subright),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_shamt(alu_shamt), .alu_funct3(alu_funct3),
        .alu_subright(alu_subright), .alu_result(alu_result),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result)
`ifdef ALU_ARB_PERF_EN
        , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
    );

    // RV32 integer ALU behaviour, used both as the bench ALU and for expected results
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] sh, input logic [2:0] f, input logic sr);
        case (f)
            3'b000:  return sr ? a - b : a + b;
            3'b001:  return a << sh;
            3'b010:  return {31'b0, $signed(a) < $signed(b)};
            3'b011:  return {31'b0, a < b};
            3'b100:  return a ^ b;
            3'b101:  return sr ? 32'($signed(a) >>> sh) : a >> sh;
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_rs1, alu_rs2, alu_shamt, alu_funct3, alu_subright);

    // Stimulus state per requester
    logic        r_v [2];
    logic [31:0] r_a [2];
    logic [31:0] r_b [2];
    logic [4:0]  r_sh[2];
    logic [2:0]  r_f [2];
    logic        r_sr[2];
    logic        r_rr[2];

    // Reference model: a pending-response queue of owner ids, last result, next-priority requester
    int          m_pend[$];
    logic [31:0] m_data;
    int          m_prio;
    int          m_pg[2];
    int          m_stall;
    bit          acc[2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend.delete();
        m_data  = 32'h0;
        m_prio  = 0;
        m_pg[0] = 0;
        m_pg[1] = 0;
        m_stall = 0;
    endtask

    task automatic set_req(input int p, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input logic [2:0] f, input logic sr);
        r_v[p] = v; r_a[p] = a; r_b[p] = b; r_sh[p] = sh; r_f[p] = f; r_sr[p] = sr;
    endtask

    // One clock cycle: apply stimulus, check combinational outputs, advance model, check registered outputs
    task automatic cycle();
        bit full, drain, has_w;
        int w;
        req0_valid = r_v[0]; req0_rs1 = r_a[0]; req0_rs2 = r_b[0]; req0_shamt = r_sh[0];
        req0_funct3 = r_f[0]; req0_subright = r_sr[0];
        req1_valid = r_v[1]; req1_rs1 = r_a[1]; req1_rs2 = r_b[1]; req1_shamt = r_sh[1];
        req1_funct3 = r_f[1]; req1_subright = r_sr[1];
        rsp0_ready = r_rr[0]; rsp1_ready = r_rr[1];
        #2;
        full  = m_pend.size() != 0;
        drain = full && r_rr[m_pend[0]];
        has_w = r_v[0] || r_v[1];
        w     = (r_v[0] && r_v[1]) ? m_prio : (r_v[0] ? 0 : 1);
        acc[0] = has_w && (w == 0) && (!full || drain);
        acc[1] = has_w && (w == 1) && (!full || drain);
        chk("req0_ready", {31'b0, req0_ready}, {31'b0, acc[0]});
        chk("req1_ready", {31'b0, req1_ready}, {31'b0, acc[1]});
        chk("alu_rs1", alu_rs1, has_w ? r_a[w] : 32'h0);
        chk("alu_rs2", alu_rs2, has_w ? r_b[w] : 32'h0);
        chk("alu_ctl", {24'b0, alu_shamt, alu_funct3}, has_w ? {24'b0, r_sh[w], r_f[w]} : 32'h0);
        chk("alu_subright", {31'b0, alu_subright}, has_w ? {31'b0, r_sr[w]} : 32'h0);
        if (drain) void'(m_pend.pop_front());
        if (acc[0] || acc[1]) begin
            m_pend.push_back(w);
            m_data = alu_fn(r_a[w], r_b[w], r_sh[w], r_f[w], r_sr[w]);
            m_prio = 1 - w;
            if (m_pg[w] < 65535) m_pg[w]++;
        end else if (has_w && m_stall < 65535) begin
            m_stall++;
        end
        @(posedge clk);
        #1;
        chk("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, (m_pend.size() != 0) && (m_pend[0] == 0)});
        chk("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, (m_pend.size() != 0) && (m_pend[0] == 1)});
        chk("rsp_result", rsp_result, m_data);
`ifdef ALU_ARB_PERF_EN
        chk("perf_grant0", {16'b0, perf_grant0}, 32'(m_pg[0]));
        chk("perf_grant1", {16'b0, perf_grant1}, 32'(m_pg[1]));
        chk("perf_stall", {16'b0, perf_stall}, 32'(m_stall));
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int stall0;
        logic [31:0] held;
        rst_n = 1'b0;
        model_reset();
        for (int p = 0; p < 2; p++) begin
            set_req(p, 1'b0, 32'h0, 32'h0, 5'd0, 3'b000, 1'b0);
            r_rr[p] = 1'b1;
        end
        r_v[0] = 1'b1;
        req0_valid = 1'b1; req0_rs1 = 32'h0; req0_rs2 = 32'h0; req0_shamt = 5'd0;
        req0_funct3 = 3'b000; req0_subright = 1'b0;
        req1_valid = 1'b1; req1_rs1 = 32'h0; req1_rs2 = 32'h0; req1_shamt = 5'd0;
        req1_funct3 = 3'b000; req1_subright = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #3;
        chk("rst_req0_ready", {31'b0, req0_ready}, 32'h0);
        chk("rst_req1_ready", {31'b0, req1_ready}, 32'h0);
        chk("rst_rsp0_valid", {31'b0, rsp0_valid}, 32'h0);
        chk("rst_rsp1_valid", {31'b0, rsp1_valid}, 32'h0);
        chk("rst_rsp_result", rsp_result, 32'h0);
        r_v[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Port 0 only: 5 + 7
        set_req(0, 1'b1, 32'd5, 32'd7, 5'd0, 3'b000, 1'b0);
        cycle();
        chk("t1_accept", {31'b0, acc[0]}, 32'h1);
        chk("t1_result", rsp_result, 32'h0000_000C);
        chk("t1_rsp0_valid", {31'b0, rsp0_valid}, 32'h1);
        chk("t1_rsp1_valid", {31'b0, rsp1_valid}, 32'h0);
        r_v[0] = 1'b0;
        cycle();

        // Both valid every cycle: strict alternation starting at port 0
        do_reset();
        set_req(0, 1'b1, 32'd10, 32'd3, 5'd0, 3'b000, 1'b1);
        set_req(1, 1'b1, 32'h8000_0000, 32'h0, 5'd4, 3'b101, 1'b1);
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("alt_grant0", {31'b0, acc[0]}, (k % 2 == 0) ? 32'h1 : 32'h0);
            chk("alt_result", rsp_result, (k % 2 == 0) ? 32'h0000_0007 : 32'hF800_0000);
            chk("alt_owner", {31'b0, rsp1_valid}, (k % 2 == 0) ? 32'h0 : 32'h1);
        end
`ifdef ALU_ARB_PERF_EN
        chk("perf_alt_g0", {16'b0, perf_grant0}, 32'd5);
        chk("perf_alt_g1", {16'b0, perf_grant1}, 32'd5);
        stall0 = int'(perf_stall);
`else
        stall0 = 0;
`endif

        // Backpressure: port 0 holds the register for 3 cycles, port 1 waits
        r_rr[0] = 1'b0;
        set_req(0, 1'b1, 32'h1234_5678, 32'h0F0F_0F0F, 5'd0, 3'b100, 1'b0);
        cycle();
        chk("bp_accept0", {31'b0, acc[0]}, 32'h1);
        held = rsp_result;
        chk("bp_held_val", held, 32'h1D3B_5977);
        r_v[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_req1_stall", {31'b0, acc[1]}, 32'h0);
            chk("bp_stable", rsp_result, 32'h1D3B_5977);
        end
`ifdef ALU_ARB_PERF_EN
        chk("perf_bp_stall", {16'b0, perf_stall}, 32'(stall0 + 3));
`endif
        r_rr[0] = 1'b1;
        cycle();
        chk("bp_req1_go", {31'b0, acc[1]}, 32'h1);
        chk("bp_rsp1", rsp_result, 32'hF800_0000);

        // Back-to-back issue on port 0
        r_v[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1'b1, 32'(100 * (k + 1)), 32'd1, 5'd0, 3'b000, 1'b0);
            cycle();
            chk("b2b_accept", {31'b0, acc[0]}, 32'h1);
            chk("b2b_valid", {31'b0, rsp0_valid}, 32'h1);
            chk("b2b_result", rsp_result, 32'(100 * (k + 1) + 1));
        end

        // Async reset while a result is pending
        r_rr[0] = 1'b0;
        cycle();
        chk("mid_full", {31'b0, rsp0_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rsp0_valid", {31'b0, rsp0_valid}, 32'h0);
        chk("mid_rsp1_valid", {31'b0, rsp1_valid}, 32'h0);
        chk("mid_rsp_result", rsp_result, 32'h0);
        chk("mid_req0_ready", {31'b0, req0_ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        r_rr[0] = 1'b1;
        set_req(1, 1'b1, 32'd9, 32'd4, 5'd0, 3'b000, 1'b1);
        cycle();
        chk("mid_init_grant", {31'b0, acc[0]}, 32'h1);

        // Randomized traffic; requests are held until accepted
        for (int k = 0; k < 400; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(r_v[p] && !acc[p])) begin
                    set_req(p, ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0, $urandom, $urandom,
                            5'($urandom), 3'($urandom), 1'($urandom));
                end
                r_rr[p] = ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
